// File: rtl/ro_bus_receiver_pkg.sv
// Shared constants, event word type and slot-decode helper for the readout-bus receiver.
package ro_pkg;

  localparam int N_CH = 19;
  localparam int CH_W = 5;

  typedef struct packed {
    logic [CH_W-1:0] chan;
    logic            eve;
    logic            pol;
  } ro_evt_t;

  // Lowest set bit of c; an all-zero count belongs to the MSB channel, which toggles on wrap.
  function automatic int lsb_index(input logic [31:0] c, input int n_ch);
    int idx;
    idx = n_ch - 1;
    for (int i = 31; i >= 0; i--) begin
      if (c[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ro_bus_receiver_if.sv
// Readout bus lines plus the channel-tagged event stream handshake.
interface ro_bus_receiver_if #(
  parameter int CH_W = ro_pkg::CH_W
);
  logic            bus_eve;
  logic            bus_pol;
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_chan;
  logic            evt_eve;
  logic            evt_pol;
  logic            frame_start;
  logic            overflow;

  modport master (
    input  bus_eve, bus_pol, evt_ready,
    output evt_valid, evt_chan, evt_eve, evt_pol, frame_start, overflow
  );

  modport slave (
    output bus_eve, bus_pol, evt_ready,
    input  evt_valid, evt_chan, evt_eve, evt_pol, frame_start, overflow
  );
endinterface

// File: rtl/ro_bus_receiver_evt_fifo.sv
// Small synchronous event FIFO; a push into a full FIFO succeeds only when a pop frees a slot on the same edge.
module ro_evt_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      level;
  logic             wr_en, rd_en;

  always_comb begin
    level = wr_q - rd_q;
    empty = (level == '0);
    full  = level[AW];
    rd_en = pop & ~empty;
    wr_en = push & (~full | rd_en);
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (wr_en) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d = wr_q + 1'b1;
    end
    if (rd_en) rd_d = rd_q + 1'b1;
  end

  assign dout = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end
endmodule

// File: rtl/ro_bus_receiver.sv
// Far-end receiver for the time-multiplexed readout bus: rebuilds the slot schedule from a local
// counter, samples both bus lines every slot and queues channel-tagged events.
module ro_bus_receiver
  import ro_pkg::*;
#(
  parameter int N_CH       = ro_pkg::N_CH,
  parameter int CH_W       = ro_pkg::CH_W,
  parameter int FIFO_DEPTH = 4,
  parameter bit EMIT_IDLE  = 1'b0
) (
  input logic         clk_master,
  input logic         reset,
  ro_bus_receiver_if.master bus
);
  localparam int DW = CH_W + 2;

  logic [N_CH-1:0] cnt_q, cnt_d;
  logic            primed_q, primed_d;
  logic [CH_W-1:0] smp_chan_q, smp_chan_d;
  logic            smp_eve_q, smp_eve_d;
  logic            smp_pol_q, smp_pol_d;
  logic            smp_vld_q, smp_vld_d;
  logic            overflow_q, overflow_d;
  logic            frame_start_q, frame_start_d;
  logic            push, pop, full, empty;
  logic [DW-1:0]   fifo_dout;

  always_comb begin
    cnt_d         = cnt_q + 1'b1;
    primed_d      = 1'b1;
    // The slot being closed is the one owned by the count we are leaving.
    smp_vld_d     = primed_q;
    smp_chan_d    = CH_W'(lsb_index(32'(cnt_q), N_CH));
    smp_eve_d     = bus.bus_eve;
    smp_pol_d     = bus.bus_pol;
    frame_start_d = &cnt_q;
    push          = smp_vld_q & (EMIT_IDLE | smp_eve_q | smp_pol_q);
    pop           = ~empty & bus.evt_ready;
    overflow_d    = overflow_q | (push & full & ~pop);
  end

  always_ff @(posedge clk_master) begin
    if (reset) begin
      cnt_q         <= '0;
      primed_q      <= 1'b0;
      smp_chan_q    <= '0;
      smp_eve_q     <= 1'b0;
      smp_pol_q     <= 1'b0;
      smp_vld_q     <= 1'b0;
      overflow_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      primed_q      <= primed_d;
      smp_chan_q    <= smp_chan_d;
      smp_eve_q     <= smp_eve_d;
      smp_pol_q     <= smp_pol_d;
      smp_vld_q     <= smp_vld_d;
      overflow_q    <= overflow_d;
      frame_start_q <= frame_start_d;
    end
  end

  ro_evt_fifo #(
    .WIDTH(DW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk_master),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  ({smp_chan_q, smp_eve_q, smp_pol_q}),
    .dout (fifo_dout),
    .full (full),
    .empty(empty)
  );

  assign bus.evt_valid                          = ~empty;
  assign {bus.evt_chan, bus.evt_eve, bus.evt_pol} = fifo_dout;
  assign bus.frame_start                        = frame_start_q;
  assign bus.overflow                           = overflow_q;
endmodule

// File: tb/tb_ro_bus_receiver.sv
// Directed bench for ro_bus_receiver with N_CH=3, CH_W=2, FIFO_DEPTH=4; one DUT per EMIT_IDLE setting.
module tb_ro_bus_receiver;
  localparam int N_CH  = 3;
  localparam int CH_W  = 2;
  localparam int DEPTH = 4;

  logic clk_master = 1'b0;
  logic reset      = 1'b1;
  int   tests      = 0;
  int   fails      = 0;

  // Channel owning the slot that closes when the counter leaves value c.
  logic [1:0] slot_tab [8] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};

  always #5 clk_master = ~clk_master;

  ro_bus_receiver_if #(.CH_W(CH_W)) bi ();
  ro_bus_receiver_if #(.CH_W(CH_W)) bz ();

  ro_bus_receiver #(.N_CH(N_CH), .CH_W(CH_W), .FIFO_DEPTH(DEPTH), .EMIT_IDLE(1'b1)) dut_i (
    .clk_master(clk_master), .reset(reset), .bus(bi)
  );
  ro_bus_receiver #(.N_CH(N_CH), .CH_W(CH_W), .FIFO_DEPTH(DEPTH), .EMIT_IDLE(1'b0)) dut_z (
    .clk_master(clk_master), .reset(reset), .bus(bz)
  );

  task automatic step();
    @(posedge clk_master);
    @(negedge clk_master);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bi.bus_eve = 1'b1; bi.bus_pol = 1'b1; bi.evt_ready = 1'b0;
    bz.bus_eve = 1'b1; bz.bus_pol = 1'b1; bz.evt_ready = 1'b0;
    repeat (3) step();
    tests++;
    if (bi.evt_valid !== 1'b0 || bi.overflow !== 1'b0 || bi.frame_start !== 1'b0 ||
        bi.evt_chan !== 2'd0 || bi.evt_eve !== 1'b0 || bi.evt_pol !== 1'b0) begin
      fails++;
      $display("FAIL reset_state_idle1: valid=%b ovf=%b fs=%b chan=%0d eve=%b pol=%b, required all 0",
               bi.evt_valid, bi.overflow, bi.frame_start, bi.evt_chan, bi.evt_eve, bi.evt_pol);
    end
    tests++;
    if (bz.evt_valid !== 1'b0 || bz.overflow !== 1'b0 || bz.frame_start !== 1'b0 ||
        bz.evt_chan !== 2'd0 || bz.evt_eve !== 1'b0 || bz.evt_pol !== 1'b0) begin
      fails++;
      $display("FAIL reset_state_idle0: valid=%b ovf=%b fs=%b chan=%0d eve=%b pol=%b, required all 0",
               bz.evt_valid, bz.overflow, bz.frame_start, bz.evt_chan, bz.evt_eve, bz.evt_pol);
    end
    bz.bus_eve = 1'b0; bz.bus_pol = 1'b0; bz.evt_ready = 1'b1;
  endtask

  // Expects reset just released; edge e samples the slot of count e-1.
  task automatic run_slot_order(input string tag);
    logic [1:0] exp_chan;
    bi.bus_eve = 1'b1; bi.bus_pol = 1'b0; bi.evt_ready = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      step();
      tests++;
      if (e < 3) begin
        if (bi.evt_valid !== 1'b0) begin
          fails++;
          $display("FAIL %s_latency e=%0d: valid=%b, required 0", tag, e, bi.evt_valid);
        end
      end else begin
        exp_chan = slot_tab[(e - 2) % 8];
        if (bi.evt_valid !== 1'b1 || bi.evt_chan !== exp_chan || bi.evt_eve !== 1'b1 || bi.evt_pol !== 1'b0) begin
          fails++;
          $display("FAIL %s_seq e=%0d: valid=%b chan=%0d eve=%b pol=%b, required 1 %0d 1 0",
                   tag, e, bi.evt_valid, bi.evt_chan, bi.evt_eve, bi.evt_pol, exp_chan);
        end
      end
    end
  endtask

  task automatic test_slot_order();
    do_reset();
    run_slot_order("slot_order");
  endtask

  task automatic test_demux();
    logic exp_v;
    do_reset();
    bz.evt_ready = 1'b1; bz.bus_pol = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      bz.bus_eve = (((e - 1) % 8) == 2) || (((e - 1) % 8) == 6);
      step();
      exp_v = ((e % 4) == 0);
      tests++;
      if (bz.evt_valid !== exp_v ||
          (exp_v && (bz.evt_chan !== 2'd1 || bz.evt_eve !== 1'b1 || bz.evt_pol !== 1'b0))) begin
        fails++;
        $display("FAIL demux e=%0d: valid=%b chan=%0d eve=%b pol=%b, required valid=%b chan=1 eve=1 pol=0",
                 e, bz.evt_valid, bz.evt_chan, bz.evt_eve, bz.evt_pol, exp_v);
      end
    end
    bz.bus_eve = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [1:0] ec [5] = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd2};
    logic       ee [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ep [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    bi.evt_ready = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      bi.bus_eve = e[1]; bi.bus_pol = e[0];
      bi.evt_ready = (e >= 13);
      step();
      if (e >= 3 && e <= 12) begin
        tests++;
        if (bi.evt_valid !== 1'b1 || bi.evt_chan !== 2'd0 || bi.evt_eve !== 1'b1 || bi.evt_pol !== 1'b0) begin
          fails++;
          $display("FAIL bp_hold e=%0d: valid=%b chan=%0d eve=%b pol=%b, required 1 0 1 0",
                   e, bi.evt_valid, bi.evt_chan, bi.evt_eve, bi.evt_pol);
        end
      end
      if (e >= 13) begin
        tests++;
        if (bi.evt_valid !== 1'b1 || bi.evt_chan !== ec[e-13] || bi.evt_eve !== ee[e-13] || bi.evt_pol !== ep[e-13]) begin
          fails++;
          $display("FAIL bp_drain e=%0d: valid=%b chan=%0d eve=%b pol=%b, required 1 %0d %b %b",
                   e, bi.evt_valid, bi.evt_chan, bi.evt_eve, bi.evt_pol, ec[e-13], ee[e-13], ep[e-13]);
        end
      end
      if (e == 6 || e == 7 || e == 17) begin
        tests++;
        if (bi.overflow !== (e != 6)) begin
          fails++;
          $display("FAIL bp_overflow e=%0d: overflow=%b, required %b", e, bi.overflow, (e != 6));
        end
      end
    end
  endtask

  task automatic test_push_pop_full();
    logic [1:0] ec [7] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0};
    logic       ee [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       ep [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       eo [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      bi.bus_eve = e[1]; bi.bus_pol = e[0];
      bi.evt_ready = (e == 7) || (e >= 9);
      step();
      if (e >= 6) begin
        tests++;
        if (bi.evt_valid !== 1'b1 || bi.evt_chan !== ec[e-6] || bi.evt_eve !== ee[e-6] ||
            bi.evt_pol !== ep[e-6] || bi.overflow !== eo[e-6]) begin
          fails++;
          $display("FAIL push_pop_full e=%0d: valid=%b chan=%0d eve=%b pol=%b ovf=%b, required 1 %0d %b %b %b",
                   e, bi.evt_valid, bi.evt_chan, bi.evt_eve, bi.evt_pol, bi.overflow,
                   ec[e-6], ee[e-6], ep[e-6], eo[e-6]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bi.bus_eve = 1'b1; bi.bus_pol = 1'b0; bi.evt_ready = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      step();
      tests++;
      if (bi.frame_start !== ((e % 8) == 0) || bz.frame_start !== ((e % 8) == 0)) begin
        fails++;
        $display("FAIL frame_start e=%0d: fs_idle1=%b fs_idle0=%b, required %b",
                 e, bi.frame_start, bz.frame_start, ((e % 8) == 0));
      end
      if (e == 10) begin
        tests++;
        if (bi.evt_valid !== 1'b1 || bi.evt_chan !== 2'd2) begin
          fails++;
          $display("FAIL wrap_slot: valid=%b chan=%0d, required 1 2", bi.evt_valid, bi.evt_chan);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bi.bus_eve = 1'b1; bi.bus_pol = 1'b0; bi.evt_ready = 1'b0;
    repeat (5) step();
    tests++;
    if (bi.evt_valid !== 1'b1 || bi.evt_chan !== 2'd0) begin
      fails++;
      $display("FAIL mid_reset_pre: valid=%b chan=%0d, required 1 0", bi.evt_valid, bi.evt_chan);
    end
    reset = 1'b1;
    step();
    tests++;
    if (bi.evt_valid !== 1'b0 || bi.overflow !== 1'b0 || bi.frame_start !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_flush: valid=%b ovf=%b fs=%b, required 0 0 0",
               bi.evt_valid, bi.overflow, bi.frame_start);
    end
    reset = 1'b0;
    run_slot_order("mid_reset");
  endtask

  initial begin
    bi.bus_eve = 1'b0; bi.bus_pol = 1'b0; bi.evt_ready = 1'b0;
    bz.bus_eve = 1'b0; bz.bus_pol = 1'b0; bz.evt_ready = 1'b0;
    @(negedge clk_master);
    test_reset();
    test_slot_order();
    test_demux();
    test_backpressure();
    test_push_pop_full();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
